// File: rtl/m_pair_bus_sequencer.sv
// m_pair_bus_sequencer: times M1/M2 load and select strobes and fetches one memory byte at M1:M2.
module m_pair_bus_sequencer #(
  parameter int HOLD = 2,
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [1:0]    op,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          ld_m1,
  output logic          ld_m2,
  output logic          sel_m,
  input  logic [AW-1:0] addr_bus,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic [AW-1:0] addr_q,
  output logic [DW-1:0] rd_data
);
  localparam int CW = $clog2(HOLD + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SEL, READ, DONE, ERR} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0] op_q;
  logic last;
  assign last = cnt == CW'(HOLD - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      rd_data <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (state == IDLE && req) op_q <= op;
      if (state == SEL && last) addr_q <= addr_bus;
      if (state == READ && last) rd_data <= mem_data;
    end
  always_comb begin
    state_d = state == IDLE ? (!req ? IDLE : op == 2'b11 ? ERR : op[1] ? SEL : LOAD)
            : state == LOAD ? (last ? DONE : LOAD)
            : state == SEL  ? (last ? READ : SEL)
            : state == READ ? (last ? DONE : READ)
            : IDLE;
    cnt_d = (state == LOAD || state == SEL || state == READ) && !last ? cnt + CW'(1) : '0;
  end
  // Strobes come from registered state only, so req/op never reach them combinationally.
  always_comb begin
    busy   = state != IDLE;
    done   = state == DONE;
    err    = state == ERR;
    ld_m1  = state == LOAD && op_q == 2'b00;
    ld_m2  = state == LOAD && op_q == 2'b01;
    sel_m  = state == SEL || state == READ;
    mem_rd = state == READ;
  end
endmodule

// File: doc/m_pair_bus_sequencer.md
# m_pair_bus_sequencer

- Controller-side counterpart of the M1/M2 address registers: it drives their load and select strobes and reads the address bus they drive.
- On command it performs one of three operations:
  - load M1 from the data bus;
  - load M2 from the data bus;
  - fetch: put M1:M2 on the address bus, latch the 16-bit address, then read one byte from memory at that address.
- Every strobe is held for a fixed number of cycles, standing in for relay settling time.
- Sits between the sequencer/control unit and the register unit and memory.

## Interface

Parameters
- HOLD, 2: cycles each strobe phase is held; legal range 1..15.
- AW, 16: address bus width.
- DW, 8: data/memory width.

Ports
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  single clock.
  - rst_n  in  1  asynchronous active-low reset.
- Command handshake:
  - req  in  1  command request; sampled only in IDLE.
  - op  in  2  command: 00 load M1, 01 load M2, 10 fetch, 11 illegal.
  - busy  out  1  high in every state other than IDLE.
  - done  out  1  one-cycle pulse on completion.
  - err  out  1  one-cycle pulse when op=11 is rejected.
- Register unit strobes:
  - ld_m1  out  1  load strobe to M1.
  - ld_m2  out  1  load strobe to M2.
  - sel_m  out  1  select strobe; M1:M2 drive the address bus.
- Address and memory:
  - addr_bus  in  AW  address bus (M1 upper byte, M2 lower byte).
  - mem_rd  out  1  memory read strobe.
  - mem_data  in  DW  memory read data.
- Results:
  - addr_q  out  AW  last address latched.
  - rd_data  out  DW  last byte read.

## Operation

- States: IDLE, LOAD, SEL, READ, DONE, ERR. Hold counter cnt is clog2(HOLD+1) bits wide.
- IDLE:
  - If req=1, the command is accepted in that cycle and op is captured into op_q.
  - op 00/01 -> LOAD; op 10 -> SEL; op 11 -> ERR.
  - cnt is cleared on every transition.
- LOAD: ld_m1 (op_q=00) or ld_m2 (op_q=01) is asserted for HOLD cycles, then -> DONE. The data bus is driven elsewhere; this block only times the strobe.
- SEL:
  - sel_m is asserted for HOLD cycles.
  - In the last SEL cycle (cnt=HOLD-1), addr_bus is captured into addr_q.
  - Then -> READ.
- READ:
  - sel_m and mem_rd are both asserted for HOLD cycles; the address stays driven through the read.
  - In the last cycle, mem_data is captured into rd_data.
  - Then -> DONE.
- DONE: done=1 for one cycle, all strobes low, -> IDLE.
- ERR: err=1 for one cycle, no strobe asserted, addr_q/rd_data unchanged, -> IDLE.
- Invariants:
  - At most one of ld_m1, ld_m2, sel_m is high in any cycle.
  - mem_rd is high only while sel_m is high.
  - ld_* and sel_m are never high in the same cycle.
- Strobes are decoded from registered state only; no combinational path from req or op to any strobe.
- Boundary conditions:
  - req while busy: ignored, not queued; op changes while busy have no effect.
  - req held high continuously: a new command is accepted in the IDLE cycle that follows DONE/ERR.
  - addr_bus or mem_data changing outside its capture cycle: no effect.
  - HOLD=1: every phase is a single cycle.

## Timing

- Reset values (asynchronous, applied immediately when rst_n falls):
  - state=IDLE, cnt=0, op_q=00;
  - busy, done, err, ld_m1, ld_m2, sel_m, mem_rd = 0;
  - addr_q = 0, rd_data = 0.
- Reset mid-operation: all strobes drop in the same instant; the in-flight command is abandoned and addr_q/rd_data return to 0. Resumes from IDLE on the first rising clk after rst_n rises.
- Cycle numbering: acceptance edge = cycle 0; strobes begin in cycle 1.
- Load (op 00/01): strobe high cycles 1..HOLD; done in cycle HOLD+1; busy high cycles 1..HOLD+1.
- Fetch (op 10):
  - sel_m high cycles 1..2*HOLD;
  - addr_q updated at the end of cycle HOLD;
  - mem_rd high cycles HOLD+1..2*HOLD;
  - rd_data updated at the end of cycle 2*HOLD;
  - done in cycle 2*HOLD+1.
- Error (op 11): err in cycle 1; IDLE in cycle 2.
- Minimum spacing between accepted commands: HOLD+2 cycles (load), 2*HOLD+2 cycles (fetch).

## Test plan

- Load M1, HOLD=2: pulse req with op=00 -> ld_m1 high exactly 2 cycles, then done 1 cycle; ld_m2/sel_m/mem_rd stay 0; busy high 3 cycles.
- Fetch, HOLD=2: addr_bus=16'hA53C, mem_data=8'h7E, req with op=10:
  - sel_m high 4 cycles, mem_rd high during the last 2;
  - addr_q=16'hA53C after cycle 2, rd_data=8'h7E after cycle 4;
  - done in cycle 5.
- Illegal op: req with op=11 -> err pulse in cycle 1, no strobes, addr_q/rd_data unchanged, back in IDLE in cycle 2.
- Busy rejection: start a fetch, then pulse req with op=00 in cycle 2 -> ignored; no ld_m1 pulse; fetch completes normally.
- Back-to-back: req held high with op=01 -> a new command accepted each IDLE cycle; ld_m2 pulses of 2 cycles separated by one done and one IDLE cycle.
- Reset mid-fetch: assert rst_n=0 in cycle 3 of a fetch -> sel_m/mem_rd drop immediately, addr_q=0, rd_data=0; after release, a fetch with addr_bus=16'h0001 yields addr_q=16'h0001.
